// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//   ID->EX pipeline register. Captures the decoded instruction, its PC, the two
//   register-file operands and the immediate for the EX stage.
//   - A redirect from EX (jal/jalr/taken branch) turns the instruction arriving
//     in EX into a bubble and starts a squash window that kills the following
//     wrong-path slots.
//   - A stall holds every EX register. The held operands still pick up
//     writeback data that targets them, so they are not stale when the stall
//     releases.
//   - On a load, writeback data for the same register bypasses the regfile read.
//
// Ports
//   clk          in   1   core clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   stall        in   1   hold all EX-stage registers this cycle
//   pc_sel_ex    in   1   EX redirect this cycle
//   inst_id      in   32  instruction in ID
//   pc_id        in   32  PC of inst_id
//   rs1_data_id  in   32  regfile read port 1
//   rs2_data_id  in   32  regfile read port 2
//   imm_id       in   32  decoded immediate
//   wb_we        in   1   writeback enable
//   wb_rd        in   5   writeback destination register
//   wb_data      in   32  writeback data
//   inst_ex      out  32  instruction in EX
//   pc_ex        out  32  PC of inst_ex
//   rs1_data_ex  out  32  rs1 operand for EX
//   rs2_data_ex  out  32  rs2 operand for EX
//   imm_ex       out  32  immediate for EX
//   valid_ex     out  1   1 = real instruction, 0 = bubble
//   flushing     out  1   squash window active
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter logic [31:0] RESET_PC     = 32'h4000_0000,
  parameter logic [31:0] NOP_INST     = 32'h0000_0013,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_sel_ex,
  input  logic [31:0] inst_id,
  input  logic [31:0] pc_id,
  input  logic [31:0] rs1_data_id,
  input  logic [31:0] rs2_data_id,
  input  logic [31:0] imm_id,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] inst_ex,
  output logic [31:0] pc_ex,
  output logic [31:0] rs1_data_ex,
  output logic [31:0] rs2_data_ex,
  output logic [31:0] imm_ex,
  output logic        valid_ex,
  output logic        flushing
);

  // The redirect slot itself is a bubble, so the counter only covers the
  // remaining FLUSH_CYCLES-1 wrong-path slots.
  localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic [31:0] r_rs1;
  logic [31:0] r_rs2;
  logic [31:0] r_imm;
  logic        r_valid;
  logic [1:0]  r_squash_cnt;

  logic        w_wb_live;
  logic        w_byp_id_rs1;
  logic        w_byp_id_rs2;
  logic        w_byp_ex_rs1;
  logic        w_byp_ex_rs2;
  logic [31:0] w_rs1_in;
  logic [31:0] w_rs2_in;

  // x0 is hardwired to zero, so a writeback to it must never be forwarded.
  assign w_wb_live    = wb_we && (wb_rd != 5'd0);

  // Bypass into a fresh load: compare against the source fields of inst_id.
  assign w_byp_id_rs1 = w_wb_live && (wb_rd == inst_id[19:15]);
  assign w_byp_id_rs2 = w_wb_live && (wb_rd == inst_id[24:20]);

  // Bypass into held operands during a stall: compare against inst_ex.
  assign w_byp_ex_rs1 = w_wb_live && (wb_rd == r_inst[19:15]);
  assign w_byp_ex_rs2 = w_wb_live && (wb_rd == r_inst[24:20]);

  assign w_rs1_in = w_byp_id_rs1 ? wb_data : rs1_data_id;
  assign w_rs2_in = w_byp_id_rs2 ? wb_data : rs2_data_id;

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inst       <= NOP_INST;
      r_pc         <= RESET_PC;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_imm        <= '0;
      r_valid      <= 1'b0;
      r_squash_cnt <= '0;
    end else if (stall) begin
      // Everything holds, including the squash counter; a redirect seen
      // during a stall is dropped. Only writeback refreshes held operands.
      if (w_byp_ex_rs1) r_rs1 <= wb_data;
      if (w_byp_ex_rs2) r_rs2 <= wb_data;
    end else begin
      // Datapath fields load every unstalled cycle; for bubbles they are
      // don't-care, which keeps the enable logic to the stall alone.
      r_pc  <= pc_id;
      r_rs1 <= w_rs1_in;
      r_rs2 <= w_rs2_in;
      r_imm <= imm_id;
      if (pc_sel_ex) begin
        r_inst       <= NOP_INST;
        r_valid      <= 1'b0;
        r_squash_cnt <= FLUSH_RELOAD;
      end else if (r_squash_cnt != 2'd0) begin
        r_inst       <= NOP_INST;
        r_valid      <= 1'b0;
        r_squash_cnt <= r_squash_cnt - 2'd1;
      end else begin
        r_inst  <= inst_id;
        r_valid <= 1'b1;
      end
    end
  end

  assign inst_ex     = r_inst;
  assign pc_ex       = r_pc;
  assign rs1_data_ex = r_rs1;
  assign rs2_data_ex = r_rs2;
  assign imm_ex      = r_imm;
  assign valid_ex    = r_valid;
  assign flushing    = (r_squash_cnt != 2'd0);

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//   Directed bench for id_ex_stage_reg: a table of single-cycle vectors with
//   hand-computed expected outputs, plus hand-written sequences for reset
//   during a squash window and during a stall.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] RPC = 32'h4000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pc_sel_ex;
  logic [31:0] inst_id;
  logic [31:0] pc_id;
  logic [31:0] rs1_data_id;
  logic [31:0] rs2_data_id;
  logic [31:0] imm_id;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] inst_ex;
  logic [31:0] pc_ex;
  logic [31:0] rs1_data_ex;
  logic [31:0] rs2_data_ex;
  logic [31:0] imm_ex;
  logic        valid_ex;
  logic        flushing;

  int n_total = 0;
  int n_pass  = 0;

  id_ex_stage_reg #(
    .RESET_PC    (RPC),
    .NOP_INST    (NOP),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .pc_sel_ex  (pc_sel_ex),
    .inst_id    (inst_id),
    .pc_id      (pc_id),
    .rs1_data_id(rs1_data_id),
    .rs2_data_id(rs2_data_id),
    .imm_id     (imm_id),
    .wb_we      (wb_we),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .inst_ex    (inst_ex),
    .pc_ex      (pc_ex),
    .rs1_data_ex(rs1_data_ex),
    .rs2_data_ex(rs2_data_ex),
    .imm_ex     (imm_ex),
    .valid_ex   (valid_ex),
    .flushing   (flushing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        sel;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [31:0] e_rs1;
    logic [31:0] e_rs2;
    logic [31:0] e_imm;
    logic        e_valid;
    logic        e_fl;
    logic        chk_ops;  // operands are don't-care on bubbles
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic apply(input vec_t v);
    stall       = v.stall;
    pc_sel_ex   = v.sel;
    inst_id     = v.inst;
    pc_id       = v.pc;
    rs1_data_id = v.rs1;
    rs2_data_id = v.rs2;
    imm_id      = v.imm;
    wb_we       = v.we;
    wb_rd       = v.rd;
    wb_data     = v.wd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " inst"},  inst_ex,             NOP);
    check({tag, " pc"},    pc_ex,               RPC);
    check({tag, " rs1"},   rs1_data_ex,         32'h0);
    check({tag, " rs2"},   rs2_data_ex,         32'h0);
    check({tag, " imm"},   imm_ex,              32'h0);
    check({tag, " valid"}, {31'b0, valid_ex},   32'h0);
    check({tag, " flush"}, {31'b0, flushing},   32'h0);
  endtask

  initial begin
    // Instruction encodings used below:
    //   00208133 add x2,x1,x2   rs1=x1 rs2=x2
    //   00A00093 addi x1,x0,10  rs1=x0 rs2 field=x10
    //   00000093 addi x1,x0,0   rs1=x0 rs2 field=x0
    //   009480B3 add x1,x9,x9   rs1=x9 rs2=x9
    //   004480B3 add x1,x9,x4   rs1=x9 rs2=x4
    //   006280B3 add x1,x5,x6   rs1=x5 rs2=x6
    //                 stall sel   inst          pc            rs1           rs2           imm           we    rd     wd             e_inst        e_pc          e_rs1         e_rs2         e_imm         val   fl    ops
    // Plain loads and load-time bypass
    vecs.push_back('{1'b0,1'b0,32'h00208133,32'h00000100,32'h00000005,32'h00000007,32'h00000000,1'b0,5'd0,32'h00000000, 32'h00208133,32'h00000100,32'h00000005,32'h00000007,32'h00000000,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h00A00093,32'h00000104,32'h0000000B,32'h00000016,32'h0000000A,1'b1,5'd3,32'h00000ABC, 32'h00A00093,32'h00000104,32'h0000000B,32'h00000016,32'h0000000A,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h00000093,32'h00000108,32'h00000000,32'h00000000,32'h00000000,1'b1,5'd0,32'hFFFFFFFF, 32'h00000093,32'h00000108,32'h00000000,32'h00000000,32'h00000000,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h009480B3,32'h0000010C,32'h00000001,32'h00000002,32'h00000011,1'b1,5'd9,32'h00000055, 32'h009480B3,32'h0000010C,32'h00000055,32'h00000055,32'h00000011,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h004480B3,32'h00000110,32'h00000003,32'h00000004,32'h00000012,1'b1,5'd9,32'h00000077, 32'h004480B3,32'h00000110,32'h00000077,32'h00000004,32'h00000012,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h004480B3,32'h00000114,32'h00000003,32'h00000004,32'h00000013,1'b0,5'd9,32'h00000077, 32'h004480B3,32'h00000114,32'h00000003,32'h00000004,32'h00000013,1'b1,1'b0,1'b1});
    // Redirect: two bubbles, flushing 1 then 0, then a real instruction
    vecs.push_back('{1'b0,1'b1,32'h00208133,32'h00000118,32'h00000001,32'h00000002,32'h00000000,1'b0,5'd0,32'h00000000, NOP,         32'h00000118,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h00208133,32'h0000011C,32'h00000001,32'h00000002,32'h00000000,1'b0,5'd0,32'h00000000, NOP,         32'h0000011C,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h00A00093,32'h00000120,32'h00000001,32'h00000002,32'h00000020,1'b0,5'd0,32'h00000000, 32'h00A00093,32'h00000120,32'h00000001,32'h00000002,32'h00000020,1'b1,1'b0,1'b1});
    // Redirect inside the squash window reloads the counter
    vecs.push_back('{1'b0,1'b1,32'h00208133,32'h00000124,32'h00000001,32'h00000002,32'h00000000,1'b0,5'd0,32'h00000000, NOP,         32'h00000124,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b1,32'h00208133,32'h00000128,32'h00000001,32'h00000002,32'h00000000,1'b0,5'd0,32'h00000000, NOP,         32'h00000128,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h00208133,32'h0000012C,32'h00000001,32'h00000002,32'h00000000,1'b0,5'd0,32'h00000000, NOP,         32'h0000012C,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h00208133,32'h00000130,32'h00000005,32'h00000007,32'h00000030,1'b0,5'd0,32'h00000000, 32'h00208133,32'h00000130,32'h00000005,32'h00000007,32'h00000030,1'b1,1'b0,1'b1});
    // Redirect during a stall is ignored; it only acts once stall is low
    vecs.push_back('{1'b1,1'b1,32'h00A00093,32'h00000134,32'h00000009,32'h00000009,32'h00000099,1'b0,5'd0,32'h00000000, 32'h00208133,32'h00000130,32'h00000005,32'h00000007,32'h00000030,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b1,32'h00A00093,32'h00000138,32'h00000009,32'h00000009,32'h00000099,1'b0,5'd0,32'h00000000, NOP,         32'h00000138,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b1,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h00A00093,32'h0000013C,32'h00000009,32'h00000009,32'h00000099,1'b0,5'd0,32'h00000000, NOP,         32'h0000013C,32'h00000000,32'h00000000,32'h00000000,1'b0,1'b0,1'b0});
    vecs.push_back('{1'b0,1'b0,32'h009480B3,32'h00000140,32'h00000008,32'h00000009,32'h00000040,1'b0,5'd0,32'h00000000, 32'h009480B3,32'h00000140,32'h00000008,32'h00000009,32'h00000040,1'b1,1'b0,1'b1});
    // Stall with writeback into the held operands (inst_ex rs1=x5, rs2=x6)
    vecs.push_back('{1'b0,1'b0,32'h006280B3,32'h00000200,32'h0000000B,32'h00000016,32'h00000050,1'b0,5'd0,32'h00000000, 32'h006280B3,32'h00000200,32'h0000000B,32'h00000016,32'h00000050,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b1,1'b0,32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b0,5'd5,32'h0000DEAD, 32'h006280B3,32'h00000200,32'h0000000B,32'h00000016,32'h00000050,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b1,1'b0,32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b1,5'd5,32'h0000DEAD, 32'h006280B3,32'h00000200,32'h0000DEAD,32'h00000016,32'h00000050,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b1,1'b0,32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b0,5'd5,32'h00001111, 32'h006280B3,32'h00000200,32'h0000DEAD,32'h00000016,32'h00000050,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b1,1'b0,32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b1,5'd6,32'h0000BEEF, 32'h006280B3,32'h00000200,32'h0000DEAD,32'h0000BEEF,32'h00000050,1'b1,1'b0,1'b1});
    vecs.push_back('{1'b0,1'b0,32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b0,5'd0,32'h00000000, 32'h00208133,32'h00000204,32'h00000001,32'h00000002,32'h00000060,1'b1,1'b0,1'b1});

    // Reset for one cycle
    rst = 1'b1;
    apply('{1'b0,1'b0,32'h0,32'h0,32'h0,32'h0,32'h0,1'b0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0});
    tick();
    check_reset_state("reset");
    rst = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i]);
      tick();
      check($sformatf("v%0d inst", i),  inst_ex, vecs[i].e_inst);
      check($sformatf("v%0d pc", i),    pc_ex,   vecs[i].e_pc);
      check($sformatf("v%0d valid", i), {31'b0, valid_ex}, {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d flush", i), {31'b0, flushing}, {31'b0, vecs[i].e_fl});
      if (vecs[i].chk_ops) begin
        check($sformatf("v%0d rs1", i), rs1_data_ex, vecs[i].e_rs1);
        check($sformatf("v%0d rs2", i), rs2_data_ex, vecs[i].e_rs2);
        check($sformatf("v%0d imm", i), imm_ex,      vecs[i].e_imm);
      end
    end

    // Reset asserted mid-squash and together with a stall: full reset state,
    // squash counter cleared so the next load is a real instruction.
    apply('{1'b0,1'b1,32'h00208133,32'h00000300,32'h00000001,32'h00000002,32'h0,1'b0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0});
    tick();
    check("pre-reset flush", {31'b0, flushing}, 32'h1);
    rst   = 1'b1;
    stall = 1'b1;
    pc_sel_ex = 1'b0;
    tick();
    check_reset_state("mid-squash reset");
    rst   = 1'b0;
    stall = 1'b0;
    apply('{1'b0,1'b0,32'h00A00093,32'h00000304,32'h00000003,32'h00000004,32'h00000070,1'b0,5'd0,32'h0, 32'h0,32'h0,32'h0,32'h0,32'h0,1'b0,1'b0,1'b0});
    tick();
    check("post-reset inst",  inst_ex,           32'h00A00093);
    check("post-reset pc",    pc_ex,             32'h00000304);
    check("post-reset valid", {31'b0, valid_ex}, 32'h1);
    check("post-reset flush", {31'b0, flushing}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
